booth_controlpath: RTL and testbench
====================================

// Module: booth_controlpath
// PURPOSE
//  Control FSM driving the 5-bit signed Booth multiplier datapath (A/Q/Q-1/M regs, ALU, counter).
//  Sequences operand load, N add/sub/shift iterations and completion; reads datapath status flags.
//  Sits beside the datapath in the multiplier top level; start/busy/done face the system side.
// PARAMETERS
//  WIDTH   5   operand width; iteration count N = WIDTH, loaded into the datapath counter
// PORTS
//  clk        in   1  system clock, all state changes on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  start      in   1  request; sampled only in S_IDLE
//  q0         in   1  datapath Q[0]
//  qm1        in   1  datapath Q(-1) flip-flop
//  eqz        in   1  datapath counter == 0
//  LdA,LdQ,LdM,clrA,clrQ,clrff  out 1 each  register load/clear strobes to datapath
//  sftA,sftQ,sftDff             out 1 each  arithmetic right-shift strobes (A:Q:Q-1)
//  add_sub    out  1  ALU op: 1 = A+M, 0 = A-M
//  EnableALU  out  1  ALU output enable
//  LdCount    out  1  load counter with WIDTH
//  decr       out  1  counter decrement
//  busy       out  1  high in every state except S_IDLE
//  done       out  1  one-cycle pulse, product valid on datapath data_out
// BEHAVIOUR
//  Moore FSM; all outputs decoded from the state register only (no input-to-output paths).
//  Reset: state = S_IDLE; every output 0 while rst_n low and in S_IDLE.
//  States / outputs asserted / next:
//   S_IDLE : none; start=1 -> S_LDM, else stay
//   S_LDM  : LdM (data_in = multiplicand) -> S_LDQ
//   S_LDQ  : LdQ, clrA, clrff, LdCount (data_in = multiplier) -> S_EVAL
//   S_EVAL : none; eqz -> S_DONE; {q0,qm1}=10 -> S_SUB; 01 -> S_ADD; 00/11 -> S_SHIFT
//   S_ADD  : EnableALU, add_sub=1, LdA -> S_SHIFT
//   S_SUB  : EnableALU, add_sub=0, LdA -> S_SHIFT
//   S_SHIFT: sftA, sftQ, sftDff, decr -> S_EVAL
//   S_DONE : done -> S_IDLE
//  add_sub defaults 0 outside S_ADD; EnableALU 0 outside S_ADD/S_SUB.
//  System side presents multiplicand on data_in during S_LDM, multiplier during S_LDQ (busy
//   rises the cycle after start is sampled; data_in must follow that order).
//  Latency start-edge to done: 3 + N*(2 or 3) + 1 cycles; WIDTH=5, all-skip = 14, all-arith = 19.
//  start during busy: ignored, no queueing; start held high through S_DONE relaunches from S_IDLE
//   on the following edge.
//  Reset mid-operation: immediate return to S_IDLE, outputs 0; datapath contents undefined until
//   next S_LDQ clears A and Q-1.
//  Counter wrap: FSM never asserts decr while eqz=1 (S_EVAL exits first).
// CONFIGURATION
//  BOOTH_CTRL_ABORT_EN defined: adds input port `abort` (1 bit); abort=1 in any state except
//   S_IDLE forces S_IDLE next edge, no done pulse, busy drops; abort ignored in S_IDLE.
//  Not defined: port absent; operation always runs to S_DONE.
// STRUCTURE
//  Shared include booth_defs.vh: WIDTH default, state encodings (localparams S_IDLE..S_DONE,
//   3-bit binary), ALU op codes (OP_ADD=1, OP_SUB=0); shared with the datapath top.
//  One sub-module booth_step_decode: {q0,qm1} -> {do_add, do_sub}, combinational, used in S_EVAL.
//  Single state register + next-state always block + output decode always block.
// TESTING
//  Bench instantiates controlpath + datapath, checks data_out at done.
//  1. rst_n low mid-S_SHIFT -> next cycle busy=0, all strobes 0; restart 3*5 -> data_out=10'h00F.
//  2. M=-3 (5'h1D), Q=5 (5'h05) -> done after 18 cycles, data_out=10'h3F1 (-15).
//  3. M=-16, Q=-16 -> data_out=10'h100 (+256); M=15, Q=-16 -> 10'h310 (-240).
//  4. M=7, Q=0 -> five skip iterations, done exactly 14 cycles after start, data_out=0.
//  5. start pulsed while busy -> ignored, single done; start held high -> back-to-back runs.
//  6. (BOOTH_CTRL_ABORT_EN) abort in 3rd S_SHIFT -> S_IDLE next edge, no done; new start OK.

Source files
------------

// File: rtl/booth_controlpath_pkg.sv
// rtl/booth_controlpath_pkg.sv - shared constants and state encoding for the Booth multiplier control path
// Purpose : operand width, 3-bit binary FSM state encoding, ALU op codes.
//           Shared by the control path and the datapath top level.
package booth_controlpath_pkg;

   // Operand width; the datapath counter is loaded with this value (N iterations).
   localparam int WIDTH = 5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LDM   = 3'd1,
      S_LDQ   = 3'd2,
      S_EVAL  = 3'd3,
      S_ADD   = 3'd4,
      S_SUB   = 3'd5,
      S_SHIFT = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   // ALU op select driven on add_sub
   localparam logic OP_ADD = 1'b1;
   localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/booth_step_decode.sv
// rtl/booth_step_decode.sv - Booth recoding of the {Q0, Q-1} bit pair
// Purpose : decides the arithmetic step of one Booth iteration.
// Ports   : q0, qm1 (in)  - datapath Q[0] and Q(-1)
//           do_add (out)  - pair 01: A <= A + M
//           do_sub (out)  - pair 10: A <= A - M
//           Pairs 00/11 assert neither (shift only).
module booth_step_decode (
   input  logic q0,
   input  logic qm1,
   output logic do_add,
   output logic do_sub
);

   assign do_add = ~q0 &  qm1;
   assign do_sub =  q0 & ~qm1;

endmodule

// File: rtl/booth_controlpath.sv
// rtl/booth_controlpath.sv - Moore control FSM for the signed Booth multiplier datapath
// Purpose : sequences multiplicand load, multiplier load/clear, N add/sub/shift iterations
//           and a one-cycle done pulse. All outputs decode from the state register only.
// Ports   : clk, rst_n (async, active low)
//           abort (in, only when BOOTH_CTRL_ABORT_EN is defined) - return to S_IDLE, no done
//           start (in)           - sampled only in S_IDLE
//           q0, qm1, eqz (in)    - datapath status: Q[0], Q(-1), counter == 0
//           LdA, LdQ, LdM, clrA, clrQ, clrff (out) - register load/clear strobes
//           sftA, sftQ, sftDff (out)               - arithmetic right shift of A:Q:Q-1
//           add_sub, EnableALU (out)               - ALU op (1 = add) and output enable
//           LdCount, decr (out)                    - counter load (WIDTH) / decrement
//           busy, done (out)                       - system-side status
// Config  : BOOTH_CTRL_ABORT_EN - adds the abort input.
module booth_controlpath
   import booth_controlpath_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
`ifdef BOOTH_CTRL_ABORT_EN
   input  logic abort,
`endif
   input  logic start,
   input  logic q0,
   input  logic qm1,
   input  logic eqz,
   output logic LdA,
   output logic LdQ,
   output logic LdM,
   output logic clrA,
   output logic clrQ,
   output logic clrff,
   output logic sftA,
   output logic sftQ,
   output logic sftDff,
   output logic add_sub,
   output logic EnableALU,
   output logic LdCount,
   output logic decr,
   output logic busy,
   output logic done
);

   state_t r_state;
   state_t w_next;
   logic   w_do_add;
   logic   w_do_sub;

   booth_step_decode u_step_decode (
      .q0     (q0),
      .qm1    (qm1),
      .do_add (w_do_add),
      .do_sub (w_do_sub)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state. eqz is tested before the bit pair so the counter is never
   // decremented past zero.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_LDM;
         S_LDM:   w_next = S_LDQ;
         S_LDQ:   w_next = S_EVAL;
         S_EVAL: begin
            if (eqz)           w_next = S_DONE;
            else if (w_do_sub) w_next = S_SUB;
            else if (w_do_add) w_next = S_ADD;
            else               w_next = S_SHIFT;
         end
         S_ADD:   w_next = S_SHIFT;
         S_SUB:   w_next = S_SHIFT;
         S_SHIFT: w_next = S_EVAL;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
`ifdef BOOTH_CTRL_ABORT_EN
      if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
`endif
   end

   // Output decode from the state register only
   always_comb begin
      LdA       = 1'b0;
      LdQ       = 1'b0;
      LdM       = 1'b0;
      clrA      = 1'b0;
      clrQ      = 1'b0;
      clrff     = 1'b0;
      sftA      = 1'b0;
      sftQ      = 1'b0;
      sftDff    = 1'b0;
      add_sub   = OP_SUB;
      EnableALU = 1'b0;
      LdCount   = 1'b0;
      decr      = 1'b0;
      busy      = (r_state != S_IDLE);
      done      = 1'b0;
      unique case (r_state)
         S_LDM: LdM = 1'b1;
         S_LDQ: begin
            LdQ     = 1'b1;
            clrA    = 1'b1;
            clrff   = 1'b1;
            LdCount = 1'b1;
         end
         S_ADD: begin
            EnableALU = 1'b1;
            add_sub   = OP_ADD;
            LdA       = 1'b1;
         end
         S_SUB: begin
            EnableALU = 1'b1;
            add_sub   = OP_SUB;
            LdA       = 1'b1;
         end
         S_SHIFT: begin
            sftA   = 1'b1;
            sftQ   = 1'b1;
            sftDff = 1'b1;
            decr   = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_booth_controlpath.sv
// tb/tb_booth_controlpath.sv - directed bench: control path plus behavioural Booth datapath
module tb_booth_controlpath;
   import booth_controlpath_pkg::*;

   logic clk;
   logic rst_n;
   logic start;
   logic q0, qm1, eqz;
   logic LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ, sftDff;
   logic add_sub, EnableALU, LdCount, decr, busy, done;
`ifdef BOOTH_CTRL_ABORT_EN
   logic abort;
`endif

   booth_controlpath dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef BOOTH_CTRL_ABORT_EN
      .abort     (abort),
`endif
      .start     (start),
      .q0        (q0),
      .qm1       (qm1),
      .eqz       (eqz),
      .LdA       (LdA),
      .LdQ       (LdQ),
      .LdM       (LdM),
      .clrA      (clrA),
      .clrQ      (clrQ),
      .clrff     (clrff),
      .sftA      (sftA),
      .sftQ      (sftQ),
      .sftDff    (sftDff),
      .add_sub   (add_sub),
      .EnableALU (EnableALU),
      .LdCount   (LdCount),
      .decr      (decr),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural datapath; A carries one guard bit so M = -16 products stay exact.
   logic [4:0] r_mcand, r_mplier, data_in;
   logic [5:0] r_a;
   logic [4:0] r_q, r_m;
   logic       r_qm1;
   logic [2:0] r_cnt;
   logic [9:0] data_out;

   always_comb data_in = LdM ? r_mcand : r_mplier;

   always_ff @(posedge clk) begin
      if (LdM) r_m <= data_in;
      if (clrA)                  r_a <= '0;
      else if (LdA && EnableALU) r_a <= add_sub ? r_a + {r_m[4], r_m} : r_a - {r_m[4], r_m};
      else if (sftA)             r_a <= {r_a[5], r_a[5:1]};
      if (LdQ)       r_q <= data_in;
      else if (sftQ) r_q <= {r_a[0], r_q[4:1]};
      if (clrff)       r_qm1 <= 1'b0;
      else if (sftDff) r_qm1 <= r_q[0];
      if (LdCount)   r_cnt <= 3'(WIDTH);
      else if (decr) r_cnt <= r_cnt - 3'd1;
   end

   assign q0       = r_q[0];
   assign qm1      = r_qm1;
   assign eqz      = (r_cnt == 3'd0);
   assign data_out = {r_a[4:0], r_q};

   // Output vector: {LdA,LdQ,LdM,clrA,clrQ,clrff,sftA,sftQ,sftDff,add_sub,EnableALU,LdCount,decr,busy,done}
   logic [14:0] w_outs;
   assign w_outs = {LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ, sftDff,
                    add_sub, EnableALU, LdCount, decr, busy, done};

   localparam logic [14:0] O_IDLE  = 15'h0000;
   localparam logic [14:0] O_LDM   = 15'h1002;
   localparam logic [14:0] O_LDQ   = 15'h2A0A;
   localparam logic [14:0] O_EVAL  = 15'h0002;
   localparam logic [14:0] O_SUB   = 15'h4012;
   localparam logic [14:0] O_ADD   = 15'h4032;
   localparam logic [14:0] O_SHIFT = 15'h01C6;
   localparam logic [14:0] O_DONE  = 15'h0003;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [14:0] trace [0:40];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one multiply; lat counts rising edges from start sampling to done.
   task automatic run_op(input logic [4:0] m, input logic [4:0] q, input bit hold,
                         input int pulse_at, output int lat, output logic [9:0] prod);
      r_mcand  = m;
      r_mplier = q;
      prod     = '0;
      lat      = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         lat      = i;
         trace[i] = w_outs;
         if (!hold) start = (i == pulse_at);
         if (done) begin
            prod = data_out;
            break;
         end
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   int         lat;
   logic [9:0] prod;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      r_mcand  = '0;
      r_mplier = '0;
`ifdef BOOTH_CTRL_ABORT_EN
      abort    = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk("reset_outs", 32'(w_outs), 32'(O_IDLE));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outs", 32'(w_outs), 32'(O_IDLE));

      // Reset during S_SHIFT, then a clean 3*5
      r_mcand  = 5'd3;
      r_mplier = 5'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (sftA) break;
         @(negedge clk);
      end
      chk("shift_reached", 32'(sftA), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", 32'(w_outs), 32'(O_IDLE));
      @(negedge clk);
      chk("held_reset_outs", 32'(w_outs), 32'(O_IDLE));
      rst_n = 1'b1;
      run_op(5'd3, 5'd5, 1'b0, 0, lat, prod);
      chk("prod_3x5", 32'(prod), 32'h00F);

      // -3 * 5 with state-by-state output trace
      run_op(5'h1D, 5'h05, 1'b0, 0, lat, prod);
      chk("lat_m3x5", 32'(lat), 32'd18);
      chk("prod_m3x5", 32'(prod), 32'h3F1);
      chk("tr_ldm", 32'(trace[1]), 32'(O_LDM));
      chk("tr_ldq", 32'(trace[2]), 32'(O_LDQ));
      chk("tr_eval", 32'(trace[3]), 32'(O_EVAL));
      chk("tr_sub", 32'(trace[4]), 32'(O_SUB));
      chk("tr_shift", 32'(trace[5]), 32'(O_SHIFT));
      chk("tr_add", 32'(trace[7]), 32'(O_ADD));
      chk("tr_done", 32'(trace[18]), 32'(O_DONE));
      @(negedge clk);
      chk("done_one_cycle", 32'(w_outs), 32'(O_IDLE));

      // Extreme operands
      run_op(5'h10, 5'h10, 1'b0, 0, lat, prod);
      chk("prod_m16xm16", 32'(prod), 32'h100);
      run_op(5'h0F, 5'h10, 1'b0, 0, lat, prod);
      chk("prod_15xm16", 32'(prod), 32'h310);

      // All-skip iterations
      run_op(5'd7, 5'd0, 1'b0, 0, lat, prod);
      chk("lat_skip", 32'(lat), 32'd14);
      chk("prod_7x0", 32'(prod), 32'h000);
      chk("tr_skip_shift", 32'(trace[4]), 32'(O_SHIFT));

      // start pulse while busy is ignored
      run_op(5'h1D, 5'h05, 1'b0, 6, lat, prod);
      chk("lat_pulse", 32'(lat), 32'd18);
      chk("prod_pulse", 32'(prod), 32'h3F1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_relaunch", 32'(w_outs), 32'(O_IDLE));
      end

      // start held high: back-to-back runs
      run_op(5'd3, 5'd5, 1'b1, 0, lat, prod);
      chk("prod_hold1", 32'(prod), 32'h00F);
      @(negedge clk);
      chk("hold_idle_gap", 32'(w_outs), 32'(O_IDLE));
      @(negedge clk);
      chk("hold_relaunch", 32'(w_outs), 32'(O_LDM));
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         @(negedge clk);
      end
      chk("hold_done2", 32'(done), 32'd1);
      chk("prod_hold2", 32'(data_out), 32'h00F);
      @(negedge clk);

`ifdef BOOTH_CTRL_ABORT_EN
      // Abort in the third S_SHIFT
      begin
         int n_shift;
         n_shift  = 0;
         r_mcand  = 5'h1D;
         r_mplier = 5'h05;
         start    = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (sftA) n_shift++;
            if (n_shift == 3) break;
            @(negedge clk);
         end
         chk("abort_third_shift", 32'(sftA), 32'd1);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         chk("abort_idle", 32'(w_outs), 32'(O_IDLE));
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(w_outs), 32'(O_IDLE));
         end
         run_op(5'd3, 5'd5, 1'b0, 0, lat, prod);
         chk("prod_after_abort", 32'(prod), 32'h00F);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
